regfile_read_stage: RTL
=======================

# regfile_read_stage

- Parametrised register-file read stage between issue and execute.
- Holds the architectural integer register file, written by `NWR` writeback ports.
- Reads two source operands for each of `NLANE` issue lanes and selects each operand's source (register, PC, zero, immediate, stable-counter half).
- Registers the result in one valid/ready pipeline slot, with write bypass, stall-time operand refresh and flush.

## Interface
Parameters:
- `NLANE`, 2, issue lanes per group (≥1)
- `NWR`, 2, writeback ports (≥1)
- `XLEN`, 32, data width
- `PAYLOAD_W`, 64, per-lane opaque payload (uop, rd, pc_next, exception…) carried unchanged

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rstn` in 1: asynchronous, active-low reset
- `wr_en` in NWR: per-port write enable
- `wr_addr` in NWR*5: write register index, port p at [5p+4:5p]
- `wr_data` in NWR*XLEN: write data
- `in_valid` in 1: issue group valid
- `in_ready` out 1: stage accepts group this cycle
- `in_lane_en` in NLANE: lane occupied within group
- `in_rj`, `in_rk` in NLANE*5: source register indices
- `in_src1_sel` in NLANE*2: 0 RF(rj), 1 PC, 2 ZERO, 3 ZERO
- `in_src2_sel` in NLANE*2: 0 RF(rk), 1 IMM, 2 CNTL, 3 CNTH
- `in_pc`, `in_imm` in NLANE*XLEN: lane PC, immediate
- `in_payload` in NLANE*PAYLOAD_W: passthrough
- `stable_counter` in 64: free-running counter
- `flush` in 1: discard held and incoming group
- `out_valid` out 1; `out_ready` in 1: downstream handshake
- `out_lane_en` out NLANE
- `out_op1`, `out_op2` out NLANE*XLEN: resolved operands
- `out_payload` out NLANE*PAYLOAD_W

## Operation
- **Storage**
  - 32×XLEN array; r0 is never written and always reads 0.
  - Several ports writing the same index in one cycle: highest port index wins.
  - Writes proceed every cycle regardless of handshake, stall or flush.
- **Accept**
  - `in_ready = (!out_valid || out_ready) && !flush`.
  - On `in_valid && in_ready` the slot captures `in_lane_en`, `in_payload` and resolved operands, and `out_valid` is set.
  - Lanes with `in_lane_en`=0 capture op1/op2/payload = 0.
- **Operand resolve (at capture)**
  - src1: RF → bypassed read of rj; PC → `in_pc`; ZERO/3 → 0.
  - src2: RF → bypassed read of rk; IMM → `in_imm`; CNTL → `stable_counter[31:0]`; CNTH → `stable_counter[63:32]`. For XLEN>32 the counter half is zero-extended.
- **Bypassed read**
  - If the index ≠0 and any enabled write port targets it this cycle, the highest-index matching port's `wr_data` is used; otherwise the array value.
- **Stall refresh**
  - While `out_valid && !out_ready`, each held operand whose sel was RF and whose index matches an enabled nonzero write updates to that write data (same priority).
  - Sel and index are kept internally per lane for this purpose.
- **Drain and flush**
  - `out_valid && out_ready` with no new capture clears `out_valid`.
  - `flush` clears `out_valid` next edge with no capture; it overrides `out_ready`.

## Timing
- Read latency: 1 cycle (capture edge → `out_*` valid).
- Write → array visible to a plain read: next cycle. Same cycle is covered via bypass.
- Back-to-back groups at full throughput when `out_ready`=1.
- `in_ready` is combinational from `out_valid`, `out_ready` and `flush`.
- Reset (`rstn`=0, async) sets:
  - all 32 registers = 0
  - `out_valid`=0
  - `out_lane_en`=0
  - `out_op1`, `out_op2`, `out_payload` = 0
- `in_ready` during reset = 1 (derived).
- Reset asserted mid-stall drops the held group; no output on release.
- Capture and refresh never coincide: capture implies the slot is empty or draining.

## Configuration
- `RF_BYPASS_EN` defined:
  - same-cycle write→read bypass and stall refresh are compiled in, as described.
- `RF_BYPASS_EN` undefined:
  - RF reads return pre-edge array contents.
  - Held operands are not refreshed.
  - The scheduler must guarantee one cycle between a write and a dependent capture, and no writes to a held group's sources during stall.

## Test plan
- **Reset:** assert `rstn`=0 mid-traffic → `out_valid`=0 and outputs 0. After release, read r5 RF → op1=0.
- **Write/read:** write r3=0x1234 via port0; next cycle issue lane0 rj=3 src1=RF → `out_op1[lane0]`=0x1234 one cycle later.
- **Same-cycle bypass and priority:** port0 r7=0xA, port1 r7=0xB, same cycle issue rj=7 → op1=0xB, and r7 holds 0xB. A write to r0=0xFF → r0 reads 0.
- **Stall refresh:** capture rk=9 (r9=1), hold `out_ready`=0, write r9=2 → op2 becomes 2 while `out_valid` stays 1 and `in_ready`=0. Without `RF_BYPASS_EN`, op2 stays 1.
- **Source muxing:**
  - src1=PC with `in_pc`=0x1c000000 → op1=0x1c000000
  - src2=CNTH with counter=0x00000005_FFFFFFFF → op2=5
  - src2=IMM with imm=0xFFFFF800 → op2=0xFFFFF800
- **Flush:** with a group held and `in_valid`=1, assert `flush` → `in_ready`=0, `out_valid`=0 next cycle, and the incoming group is not captured.

Source files
------------

// File: rtl/regfile_read_stage.sv
// regfile_read_stage: architectural integer register file plus a one-slot
// operand read stage between issue and execute.
// Optional feature macro: RF_BYPASS_EN. When it is defined, same-cycle
// write->read bypass and held-operand refresh during a stall are compiled in.
// It is undefined by default, and then RF reads return pre-edge array contents.
//
// Handshake: a group transfers in when in_valid && in_ready, and out when
// out_valid && out_ready. in_ready = (!out_valid || out_ready) && !flush, so a
// capture only happens into an empty or draining slot. flush empties the slot
// on the next edge and blocks capture, whatever out_ready is.
module regfile_read_stage #(
    parameter int NLANE     = 2,
    parameter int NWR       = 2,
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR*5-1:0]           wr_addr,
    input  logic [NWR*XLEN-1:0]        wr_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NLANE-1:0]           in_lane_en,
    input  logic [NLANE*5-1:0]         in_rj,
    input  logic [NLANE*5-1:0]         in_rk,
    input  logic [NLANE*2-1:0]         in_src1_sel,
    input  logic [NLANE*2-1:0]         in_src2_sel,
    input  logic [NLANE*XLEN-1:0]      in_pc,
    input  logic [NLANE*XLEN-1:0]      in_imm,
    input  logic [NLANE*PAYLOAD_W-1:0] in_payload,
    input  logic [63:0]                stable_counter,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NLANE-1:0]           out_lane_en,
    output logic [NLANE*XLEN-1:0]      out_op1,
    output logic [NLANE*XLEN-1:0]      out_op2,
    output logic [NLANE*PAYLOAD_W-1:0] out_payload
);

    localparam logic [1:0] SRC1_RF   = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC2_RF   = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_CNTL = 2'd2;
    localparam logic [1:0] SRC2_CNTH = 2'd3;

    logic [XLEN-1:0] rf [32];

    logic            capture;
    logic [XLEN-1:0] rd1 [NLANE];
    logic [XLEN-1:0] rd2 [NLANE];

    logic [NLANE*XLEN-1:0]      cap_op1;
    logic [NLANE*XLEN-1:0]      cap_op2;
    logic [NLANE*PAYLOAD_W-1:0] cap_pay;

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign capture  = in_valid && in_ready;

`ifdef RF_BYPASS_EN
    // Per-lane source bookkeeping kept only for stall refresh.
    logic [NLANE-1:0]      hold_s1_rf;
    logic [NLANE-1:0]      hold_s2_rf;
    logic [NLANE*5-1:0]    hold_rj;
    logic [NLANE*5-1:0]    hold_rk;
    logic [NLANE*XLEN-1:0] ref_op1;
    logic [NLANE*XLEN-1:0] ref_op2;
    logic [XLEN:0]         m1;
    logic [XLEN:0]         m2;
    logic [XLEN:0]         h1;
    logic [XLEN:0]         h2;

    // Returns {hit, data} for the highest-index enabled write port that
    // targets idx this cycle; r0 never matches.
    function automatic logic [XLEN:0] wr_match(
        input logic [4:0]          idx,
        input logic [NWR-1:0]      en,
        input logic [NWR*5-1:0]    addr,
        input logic [NWR*XLEN-1:0] data
    );
        logic [XLEN:0] r;
        r = '0;
        for (int p = 0; p < NWR; p++) begin
            if (en[p] && (idx != 5'd0) && (addr[5*p +: 5] == idx)) begin
                r = {1'b1, data[XLEN*p +: XLEN]};
            end
        end
        return r;
    endfunction
`endif

    // Register file writes: every cycle, r0 skipped, later ports override earlier.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[5*p +: 5] != 5'd0)) begin
                    rf[wr_addr[5*p +: 5]] <= wr_data[XLEN*p +: XLEN];
                end
            end
        end
    end

    // Register reads for both sources of each lane, bypassed when enabled.
    always_comb begin
`ifdef RF_BYPASS_EN
        m1 = '0;
        m2 = '0;
`endif
        for (int l = 0; l < NLANE; l++) begin
            rd1[l] = rf[in_rj[5*l +: 5]];
            rd2[l] = rf[in_rk[5*l +: 5]];
`ifdef RF_BYPASS_EN
            m1 = wr_match(in_rj[5*l +: 5], wr_en, wr_addr, wr_data);
            m2 = wr_match(in_rk[5*l +: 5], wr_en, wr_addr, wr_data);
            if (m1[XLEN]) rd1[l] = m1[XLEN-1:0];
            if (m2[XLEN]) rd2[l] = m2[XLEN-1:0];
`endif
        end
    end

    // Operand source selection for the group being captured; idle lanes are 0.
    always_comb begin
        cap_op1 = '0;
        cap_op2 = '0;
        cap_pay = '0;
        for (int l = 0; l < NLANE; l++) begin
            if (in_lane_en[l]) begin
                case (in_src1_sel[2*l +: 2])
                    SRC1_RF: cap_op1[XLEN*l +: XLEN] = rd1[l];
                    SRC1_PC: cap_op1[XLEN*l +: XLEN] = in_pc[XLEN*l +: XLEN];
                    default: cap_op1[XLEN*l +: XLEN] = '0;
                endcase
                case (in_src2_sel[2*l +: 2])
                    SRC2_RF:   cap_op2[XLEN*l +: XLEN] = rd2[l];
                    SRC2_IMM:  cap_op2[XLEN*l +: XLEN] = in_imm[XLEN*l +: XLEN];
                    SRC2_CNTL: cap_op2[XLEN*l +: XLEN] = XLEN'(stable_counter[31:0]);
                    SRC2_CNTH: cap_op2[XLEN*l +: XLEN] = XLEN'(stable_counter[63:32]);
                    default:   cap_op2[XLEN*l +: XLEN] = '0;
                endcase
                cap_pay[PAYLOAD_W*l +: PAYLOAD_W] = in_payload[PAYLOAD_W*l +: PAYLOAD_W];
            end
        end
    end

`ifdef RF_BYPASS_EN
    // Refreshed copies of held operands that read a register being written now.
    always_comb begin
        ref_op1 = out_op1;
        ref_op2 = out_op2;
        h1      = '0;
        h2      = '0;
        for (int l = 0; l < NLANE; l++) begin
            h1 = wr_match(hold_rj[5*l +: 5], wr_en, wr_addr, wr_data);
            h2 = wr_match(hold_rk[5*l +: 5], wr_en, wr_addr, wr_data);
            if (hold_s1_rf[l] && h1[XLEN]) ref_op1[XLEN*l +: XLEN] = h1[XLEN-1:0];
            if (hold_s2_rf[l] && h2[XLEN]) ref_op2[XLEN*l +: XLEN] = h2[XLEN-1:0];
        end
    end

    // Remember which held operands came from the register file, and from where.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_s1_rf <= '0;
            hold_s2_rf <= '0;
            hold_rj    <= '0;
            hold_rk    <= '0;
        end else if (capture) begin
            for (int l = 0; l < NLANE; l++) begin
                hold_s1_rf[l] <= in_lane_en[l] && (in_src1_sel[2*l +: 2] == SRC1_RF);
                hold_s2_rf[l] <= in_lane_en[l] && (in_src2_sel[2*l +: 2] == SRC2_RF);
            end
            hold_rj <= in_rj;
            hold_rk <= in_rk;
        end
    end
`endif

    // Output slot: capture, drain/flush, or (with bypass) refresh while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid   <= 1'b0;
            out_lane_en <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_payload <= '0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_lane_en <= in_lane_en;
            out_op1     <= cap_op1;
            out_op2     <= cap_op2;
            out_payload <= cap_pay;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
`ifdef RF_BYPASS_EN
        else if (out_valid) begin
            out_op1 <= ref_op1;
            out_op2 <= ref_op2;
        end
`endif
    end

endmodule
